// File: rtl/shape_processor_cfg_initiator.sv
// Bus-side initiator for the shape processor CTRL SFR: queues (shape, operation) commands,
// writes each one, samples error, reads CTRL back and classifies the outcome against a CTRL shadow.
module shape_processor_cfg_initiator #(
  parameter int                 DEPTH      = 4,
  parameter int                 SHAPE_W    = 3,
  parameter int                 SHAPE_LSB  = 0,
  parameter int                 OP_W       = 3,
  parameter int                 OP_LSB     = 8,
  parameter logic [SHAPE_W-1:0] KEEP_SHAPE = 3'h7,
  parameter logic [OP_W-1:0]    KEEP_OP    = 3'h7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [SHAPE_W-1:0] cmd_shape,
  input  logic [OP_W-1:0]    cmd_operation,
  output logic               write,
  output logic [31:0]        write_data,
  output logic               read,
  input  logic [31:0]        read_data,
  input  logic               error,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [1:0]         rsp_status,
  output logic [SHAPE_W-1:0] rsp_shape,
  output logic [OP_W-1:0]    rsp_operation,
  output logic               busy
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int CMD_W = SHAPE_W + OP_W;

  typedef enum logic [2:0] {
    ST_INIT_RD, ST_INIT_CAP, ST_IDLE, ST_WR, ST_WR_CHK, ST_RD, ST_RD_CAP, ST_RSP
  } state_t;

  typedef enum logic [1:0] {
    STAT_OK       = 2'd0,
    STAT_REJECTED = 2'd1,
    STAT_MISMATCH = 2'd2
  } status_t;

  state_t state;

  // Command FIFO
  logic [CMD_W-1:0] fifo_mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, empty, push, pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full && (state != ST_INIT_RD) && (state != ST_INIT_CAP);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == ST_IDLE) && !empty;
  assign busy      = (state != ST_IDLE) || !empty;

  // NOTE: storage array has no reset; only the pointers and count need one to flush it.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_shape, cmd_operation};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head of FIFO, and the write word it would produce
  logic [SHAPE_W-1:0] head_shape;
  logic [OP_W-1:0]    head_op;
  logic [31:0]        head_word;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    {head_shape, head_op} = fifo_mem[rd_ptr];
    head_word = '0;
    head_word[SHAPE_LSB +: SHAPE_W] = head_shape;
    head_word[OP_LSB +: OP_W]       = head_op;
  end

  // Latched command, captured error and CTRL shadow
  logic [SHAPE_W-1:0] cur_shape, shadow_shape, exp_shape, rb_shape;
  logic [OP_W-1:0]    cur_op, shadow_op, exp_op, rb_op;
  logic               err_q;
  status_t            status;

  assign rb_shape = read_data[SHAPE_LSB +: SHAPE_W];
  assign rb_op    = read_data[OP_LSB +: OP_W];

  // Only the two CTRL fields of the readback carry meaning
  logic unused_read_bits;
  assign unused_read_bits = ^read_data;

  always_comb begin
    exp_shape = (cur_shape == KEEP_SHAPE) ? shadow_shape : cur_shape;
    exp_op    = (cur_op == KEEP_OP) ? shadow_op : cur_op;
    if (!err_q && rb_shape == exp_shape && rb_op == exp_op)
      status = STAT_OK;
    else if (err_q && rb_shape == shadow_shape && rb_op == shadow_op)
      status = STAT_REJECTED;
    else
      status = STAT_MISMATCH;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_INIT_RD;
      write         <= 1'b0;
      write_data    <= '0;
      read          <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_status    <= '0;
      rsp_shape     <= '0;
      rsp_operation <= '0;
      cur_shape     <= '0;
      cur_op        <= '0;
      shadow_shape  <= '0;
      shadow_op     <= '0;
      err_q         <= 1'b0;
    end else begin
      case (state)
        // Read strobe rises on the second INIT_RD cycle so it is never high during reset
        ST_INIT_RD: begin
          if (!read) begin
            read <= 1'b1;
          end else begin
            read  <= 1'b0;
            state <= ST_INIT_CAP;
          end
        end
        ST_INIT_CAP: begin
          shadow_shape <= rb_shape;
          shadow_op    <= rb_op;
          state        <= ST_IDLE;
        end
        ST_IDLE: begin
          if (!empty) begin
            cur_shape  <= head_shape;
            cur_op     <= head_op;
            write      <= 1'b1;
            write_data <= head_word;
            state      <= ST_WR;
          end
        end
        ST_WR: begin
          write <= 1'b0;
          state <= ST_WR_CHK;
        end
        ST_WR_CHK: begin
          err_q <= error;
          read  <= 1'b1;
          state <= ST_RD;
        end
        ST_RD: begin
          read  <= 1'b0;
          state <= ST_RD_CAP;
        end
        ST_RD_CAP: begin
          rsp_valid     <= 1'b1;
          rsp_status    <= status;
          rsp_shape     <= rb_shape;
          rsp_operation <= rb_op;
          shadow_shape  <= rb_shape;
          shadow_op     <= rb_op;
          state         <= ST_RSP;
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_INIT_RD;
      endcase
    end
  end

endmodule

// File: tb/tb_shape_processor_cfg_initiator.sv
// Self-checking bench for shape_processor_cfg_initiator: the bench plays the SFR responder and
// predicts each response from a CTRL shadow model kept at command level.
module tb_shape_processor_cfg_initiator;

  localparam logic [31:0] JUNK   = 32'hA5A5_0506;
  localparam logic [1:0]  S_OK   = 2'd0;
  localparam logic [1:0]  S_REJ  = 2'd1;
  localparam logic [1:0]  S_MISM = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_shape, cmd_operation;
  logic        write, read, error;
  logic [31:0] write_data, read_data;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_status;
  logic [2:0]  rsp_shape, rsp_operation;
  logic        busy;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  logic [2:0] mdl_shape, mdl_op;

  always #5 clk = ~clk;

  shape_processor_cfg_initiator dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_shape(cmd_shape), .cmd_operation(cmd_operation),
    .write(write), .write_data(write_data),
    .read(read), .read_data(read_data), .error(error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_shape(rsp_shape), .rsp_operation(rsp_operation),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Initialisation read: one read pulse, CTRL returned the next cycle, then ready for commands
  task automatic init_seq(input logic [31:0] rb);
    int n = 0;
    while (!read && n < 10) begin
      check("init_no_write", write, 0);
      @(negedge clk);
      n++;
    end
    check("init_read", read, 1);
    @(negedge clk);
    read_data = rb;
    check("init_read_one_cycle", read, 0);
    check("init_cmd_ready_low", cmd_ready, 0);
    @(negedge clk);
    read_data = JUNK;
    check("init_cmd_ready", cmd_ready, 1);
    check("init_busy_clear", busy, 0);
    check("init_no_write_after", write, 0);
    mdl_shape = rb[2:0];
    mdl_op    = rb[10:8];
  endtask

  // One full command: push, write at t, error at t+1, read at t+2, readback at t+3, response at t+4
  task automatic do_cmd(input logic [2:0] cs, input logic [2:0] co, input logic er,
                        input logic [31:0] rb, input int hold);
    logic [2:0]  es, eo, rs, ro;
    logic [1:0]  st;
    logic [31:0] wd;
    int n;
    es = (cs == 3'h7) ? mdl_shape : cs;
    eo = (co == 3'h7) ? mdl_op : co;
    rs = rb[2:0];
    ro = rb[10:8];
    if (er) st = (rs == mdl_shape && ro == mdl_op) ? S_REJ : S_MISM;
    else    st = (rs == es && ro == eo) ? S_OK : S_MISM;
    wd = {21'd0, co, 5'd0, cs};

    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_shape = cs;
    cmd_operation = co;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!write && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("write_seen", write, 1);
    check("write_data", write_data, wd);
    check("write_not_read", read, 0);
    @(negedge clk);
    error = er;
    check("write_one_cycle", write, 0);
    check("no_read_t1", read, 0);
    @(negedge clk);
    error = 1'b0;
    check("read_at_t2", read, 1);
    check("read_not_write", write, 0);
    @(negedge clk);
    read_data = rb;
    check("read_one_cycle", read, 0);
    check("no_rsp_t3", rsp_valid, 0);
    @(negedge clk);
    read_data = JUNK;
    check("rsp_valid_t4", rsp_valid, 1);
    check("rsp_status", rsp_status, st);
    check("rsp_shape", rsp_shape, rs);
    check("rsp_operation", rsp_operation, ro);
    check("rsp_busy", busy, 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rsp_held", rsp_valid, 1);
      check("rsp_status_stable", rsp_status, st);
      check("rsp_shape_stable", rsp_shape, rs);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_consumed", rsp_valid, 0);
    check("idle_not_busy", busy, 0);
    mdl_shape = rs;
    mdl_op    = ro;
  endtask

  initial begin
    int wr_cnt;
    int n;
    logic [2:0]  rcs, rco, xs, xo;
    logic        rer;
    logic [31:0] rrb;

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_shape = '0;
    cmd_operation = '0;
    error = 1'b0;
    read_data = JUNK;
    rsp_ready = 1'b0;
    mdl_shape = '0;
    mdl_op = '0;
    repeat (3) @(negedge clk);
    check("reset_write", write, 0);
    check("reset_read", read, 0);
    check("reset_write_data", write_data, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_fields", {rsp_status, rsp_shape, rsp_operation}, 0);
    check("reset_cmd_ready", cmd_ready, 0);
    check("reset_busy", busy, 1);
    rst = 1'b0;
    init_seq(32'h0000_0102);

    // Directed sequence from a known shadow of shape=2 op=1
    do_cmd(3'd1, 3'd3, 1'b0, 32'h0000_0301, 0);
    do_cmd(3'd7, 3'd2, 1'b0, 32'h0000_0201, 1);
    do_cmd(3'd5, 3'd0, 1'b1, 32'h0000_0201, 0);
    do_cmd(3'd2, 3'd2, 1'b0, 32'h0000_0000, 2);
    do_cmd(3'd7, 3'd7, 1'b0, 32'h0000_0000, 0);

    // Back-pressure: one in flight plus DEPTH queued, sixth offer refused
    wr_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (write) wr_cnt++;
      check("ovf_ready", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_shape = 3'(i);
      cmd_operation = 3'(i + 1);
    end
    @(negedge clk);
    if (write) wr_cnt++;
    check("ovf_full_ready_low", cmd_ready, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (write) wr_cnt++;
    end
    cmd_valid = 1'b0;
    check("ovf_single_write", wr_cnt, 1);
    check("ovf_rsp_waiting", rsp_valid, 1);
    check("ovf_still_full", cmd_ready, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n = 0;
    while (!write && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("ovf_second_write", write, 1);
    check("ovf_second_data", write_data, 32'h0000_0201);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_read", read, 0);
    check("midrst_write", write, 0);
    check("midrst_cmd_ready", cmd_ready, 0);
    check("midrst_busy", busy, 1);
    rst = 1'b0;
    init_seq(32'h0000_0405);
    wr_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (write || rsp_valid) wr_cnt++;
    end
    check("midrst_fifo_flushed", wr_cnt, 0);

    // Randomised commands against the shadow model
    for (int i = 0; i < 24; i++) begin
      rcs = 3'($urandom_range(0, 7));
      rco = 3'($urandom_range(0, 7));
      rer = 1'($urandom_range(0, 1));
      xs = (rcs == 3'h7) ? mdl_shape : rcs;
      xo = (rco == 3'h7) ? mdl_op : rco;
      case ($urandom_range(0, 2))
        0:       rrb = {21'd0, xo, 5'd0, xs};
        1:       rrb = {21'd0, mdl_op, 5'd0, mdl_shape};
        default: rrb = {21'd0, 3'($urandom_range(0, 7)), 5'd0, 3'($urandom_range(0, 7))};
      endcase
      do_cmd(rcs, rco, rer, rrb, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule
